// File: rtl/alu_pkg.sv
// Shared constants for the ALU command engine: data width, opcodes, FSM states.
package alu_pkg;

   localparam int unsigned DataWidth = 8;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_SHR = 4'h7;
   localparam logic [3:0] OP_EQ  = 4'h8;
   localparam logic [3:0] OP_GT  = 4'h9;
   localparam logic [3:0] OP_LT  = 4'hA;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResp
   } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: one result byte plus carry/borrow and illegal-opcode flags.
module alu_core
   import alu_pkg::*;
(
   input  logic [DataWidth-1:0] a_i,
   input  logic [DataWidth-1:0] b_i,
   input  logic [3:0]           sel_i,
   output logic [DataWidth-1:0] out_o,
   output logic                 carry_o,
   output logic                 err_o
);

   logic [DataWidth:0] sum;
   logic [DataWidth:0] diff;

   // Top bit of the widened difference is the borrow (set when A < B).
   assign sum  = {1'b0, a_i} + {1'b0, b_i};
   assign diff = {1'b0, a_i} - {1'b0, b_i};

   // Decode the select code; unlisted codes give a zero result with err set.
   always_comb begin
      out_o   = '0;
      carry_o = 1'b0;
      err_o   = 1'b0;
      case (sel_i)
         OP_ADD: {carry_o, out_o} = sum;
         OP_SUB: {carry_o, out_o} = diff;
         OP_AND: out_o = a_i & b_i;
         OP_OR:  out_o = a_i | b_i;
         OP_XOR: out_o = a_i ^ b_i;
         OP_NOT: out_o = ~a_i;
         OP_SHL: begin
            out_o   = {a_i[DataWidth-2:0], 1'b0};
            carry_o = a_i[DataWidth-1];
         end
         OP_SHR: begin
            out_o   = {1'b0, a_i[DataWidth-1:1]};
            carry_o = a_i[0];
         end
         OP_EQ:  out_o = (a_i == b_i) ? 8'h01 : 8'h00;
         OP_GT:  out_o = (a_i > b_i)  ? 8'h01 : 8'h00;
         OP_LT:  out_o = (a_i < b_i)  ? 8'h01 : 8'h00;
         default: err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_cmd_engine.sv
// Single-command-in-flight ALU engine with accumulator, valid/ready command and response ports.
module alu_cmd_engine
   import alu_pkg::*;
#(
   parameter logic [DataWidth-1:0] ACC_INIT = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           cmd_op,
   input  logic [DataWidth-1:0] cmd_a,
   input  logic [DataWidth-1:0] cmd_b,
   input  logic                 cmd_use_acc,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DataWidth-1:0] rsp_data,
   output logic                 rsp_zero,
   output logic                 rsp_carry,
   output logic                 rsp_err,
   output logic [7:0]           op_count
);

   state_e               state_q, state_d;
   logic [3:0]           op_q;
   logic [DataWidth-1:0] a_q, b_q, acc_q;
   logic [DataWidth-1:0] rsp_data_q;
   logic                 rsp_zero_q, rsp_carry_q, rsp_err_q;
   logic [7:0]           op_count_q;
   logic [DataWidth-1:0] alu_out;
   logic                 alu_carry, alu_err;
   logic                 cmd_fire, rsp_fire;

   alu_core u_alu_core (
      .a_i     (a_q),
      .b_i     (b_q),
      .sel_i   (op_q),
      .out_o   (alu_out),
      .carry_o (alu_carry),
      .err_o   (alu_err)
   );

   // Handshakes and outputs; cmd_ready is gated by rst so it is low throughout reset.
   always_comb begin
      cmd_ready = (state_q == StIdle) && !rst;
      rsp_valid = (state_q == StResp);
      cmd_fire  = cmd_valid && cmd_ready;
      rsp_fire  = rsp_valid && rsp_ready;
      rsp_data  = rsp_data_q;
      rsp_zero  = rsp_zero_q;
      rsp_carry = rsp_carry_q;
      rsp_err   = rsp_err_q;
      op_count  = op_count_q;
   end

   // Next-state logic: IDLE -> EXEC -> RESP -> IDLE, no bypass from RESP.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cmd_fire) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (rsp_fire) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Datapath: capture command, register result, update accumulator and counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= ACC_INIT;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_carry_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         op_count_q  <= '0;
      end else begin
         if (cmd_fire) begin
            op_q <= cmd_op;
            a_q  <= cmd_use_acc ? acc_q : cmd_a;
            b_q  <= cmd_b;
         end
         if (state_q == StExec) begin
            rsp_data_q  <= alu_out;
            rsp_zero_q  <= (alu_out == '0);
            rsp_carry_q <= alu_carry;
            rsp_err_q   <= alu_err;
            if (!alu_err) acc_q <= alu_out;
         end
         if (rsp_fire) op_count_q <= op_count_q + 8'd1;
      end
   end

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Self-checking bench: directed cases plus random commands against a behavioural model.
module tb_alu_cmd_engine;

   localparam logic [7:0] AccInit = 8'h5A;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_use_acc;
   logic [3:0] cmd_op;
   logic [7:0] cmd_a, cmd_b;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_zero, rsp_carry, rsp_err;
   logic [7:0] op_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   logic [7:0] m_acc;
   logic [7:0] m_count;

   always #5 clk = ~clk;

   alu_cmd_engine #(.ACC_INIT(AccInit)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_use_acc (cmd_use_acc),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_zero    (rsp_zero),
      .rsp_carry   (rsp_carry),
      .rsp_err     (rsp_err),
      .op_count    (op_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference result as {err, zero, carry, data}
   function automatic logic [10:0] model(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
      int         r;
      logic [7:0] d;
      logic       c, e;
      c = 1'b0;
      e = 1'b0;
      d = 8'h00;
      case (op)
         4'd0: begin r = int'(a) + int'(b); d = r[7:0]; c = (r > 255); end
         4'd1: begin r = int'(a) - int'(b); d = r[7:0]; c = (a < b); end
         4'd2: d = a & b;
         4'd3: d = a | b;
         4'd4: d = a ^ b;
         4'd5: d = ~a;
         4'd6: begin r = int'(a) * 2; d = r[7:0]; c = (a >= 8'd128); end
         4'd7: begin d = a / 2; c = (a % 2 == 1); end
         4'd8: d = (a == b) ? 8'd1 : 8'd0;
         4'd9: d = (a > b) ? 8'd1 : 8'd0;
         4'd10: d = (a < b) ? 8'd1 : 8'd0;
         default: e = 1'b1;
      endcase
      return {e, (d == 8'h00), c, d};
   endfunction

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 20 && !cmd_ready; i++) begin
         @(posedge clk);
         #1;
      end
      check({tag, "_ready"}, cmd_ready, 1'b1);
   endtask

   // Issue one command, stall the response `stall` cycles, then complete it.
   task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic use_acc, input int stall, input string tag);
      logic [10:0] exp;
      exp = model(op, use_acc ? m_acc : a, b);
      cmd_op      = op;
      cmd_a       = a;
      cmd_b       = b;
      cmd_use_acc = use_acc;
      cmd_valid   = 1'b1;
      wait_ready(tag);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check({tag, "_exec_valid"}, rsp_valid, 1'b0);
      check({tag, "_exec_ready"}, cmd_ready, 1'b0);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, rsp_valid, 1'b1);
      for (int i = 0; i <= stall; i++) begin
         check({tag, "_data"}, rsp_data, exp[7:0]);
         check({tag, "_carry"}, rsp_carry, exp[8]);
         check({tag, "_zero"}, rsp_zero, exp[9]);
         check({tag, "_err"}, rsp_err, exp[10]);
         check({tag, "_hold_count"}, op_count, m_count);
         check({tag, "_hold_ready"}, cmd_ready, 1'b0);
         if (i < stall) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, rsp_valid, 1'b1);
         end
      end
      // Offer a competing command in the completing cycle; it must not be taken.
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 4'h0;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      if (!exp[10]) m_acc = exp[7:0];
      m_count = m_count + 8'd1;
      check({tag, "_done_valid"}, rsp_valid, 1'b0);
      check({tag, "_done_count"}, op_count, m_count);
      check({tag, "_no_bypass"}, cmd_ready, 1'b1);
   endtask

   // Start a command and pulse reset in EXEC (phase 0) or RESP (phase 1).
   task automatic reset_during(input int phase, input string tag);
      cmd_op      = 4'h0;
      cmd_a       = 8'h11;
      cmd_b       = 8'h22;
      cmd_use_acc = 1'b0;
      cmd_valid   = 1'b1;
      wait_ready(tag);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (phase == 1) begin
         @(posedge clk);
         #1;
         check({tag, "_pre_valid"}, rsp_valid, 1'b1);
      end
      rst = 1'b1;
      #1;
      check({tag, "_rst_cmd_ready"}, cmd_ready, 1'b0);
      check({tag, "_rst_valid"}, rsp_valid, 1'b0);
      check({tag, "_rst_count"}, op_count, 8'h00);
      check({tag, "_rst_data"}, rsp_data, 8'h00);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_acc   = AccInit;
      m_count = 8'h00;
      #1;
      check({tag, "_post_ready"}, cmd_ready, 1'b1);
      check({tag, "_post_valid"}, rsp_valid, 1'b0);
      // Accumulator must be back at its initial value.
      run_cmd(4'h0, 8'h00, 8'h00, 1'b1, 0, {tag, "_acc"});
   endtask

   initial begin
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_op      = 4'h0;
      cmd_a       = 8'h00;
      cmd_b       = 8'h00;
      cmd_use_acc = 1'b0;
      rsp_ready   = 1'b0;
      m_acc       = AccInit;
      m_count     = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("in_rst_cmd_ready", cmd_ready, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_data", rsp_data, 8'h00);
      check("rst_flags", {rsp_zero, rsp_carry, rsp_err}, 3'b000);
      check("rst_count", op_count, 8'h00);

      // Directed cases
      run_cmd(4'h0, 8'h0A, 8'h05, 1'b0, 0, "add");
      run_cmd(4'h1, 8'h05, 8'h0A, 1'b0, 0, "sub");
      run_cmd(4'h0, 8'hFF, 8'h01, 1'b0, 0, "add_wrap");
      run_cmd(4'h0, 8'h10, 8'h20, 1'b0, 0, "chain_add");
      run_cmd(4'h0, 8'h00, 8'h05, 1'b1, 0, "chain_acc");
      run_cmd(4'h6, 8'h00, 8'h00, 1'b1, 0, "chain_shl");
      check("chain_acc_val", m_acc, 8'h6A);
      run_cmd(4'hC, 8'h33, 8'h00, 1'b0, 0, "illegal");
      run_cmd(4'h0, 8'h00, 8'h00, 1'b1, 0, "illegal_acc");
      check("illegal_acc_val", m_acc, 8'h6A);
      run_cmd(4'h4, 8'hA5, 8'h3C, 1'b0, 5, "backpressure");
      reset_during(0, "rst_exec");
      reset_during(1, "rst_resp");
      run_cmd(4'h0, 8'h01, 8'h01, 1'b0, 0, "post_rst_add");

      // Random commands; enough of them to wrap op_count.
      for (int n = 0; n < 270; n++) begin
         run_cmd(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
